// File: rtl/pmodacl2_spi_master.sv
// SPI mode-0 master for the ADXL362 on a PmodACL2: issues 3-byte register write,
// register read and FIFO read frames and returns the read bytes on rd_data.
module pmodacl2_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  cmd,
  input  logic [7:0]  address,
  input  logic [7:0]  wr_data,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        SCLK,
  output logic        MOSI,
  output logic        nCS,
  input  logic        MISO
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CS_SETUP   = 3'd1,
    SHIFT_LOW  = 3'd2,
    SHIFT_HIGH = 3'd3,
    CS_HOLD    = 3'd4,
    CS_GAP     = 3'd5,
    DONE       = 3'd6
  } state_t;

  localparam logic [7:0] HALF_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [1:0] CMD_WRITE   = 2'd0;
  localparam logic [1:0] CMD_READ    = 2'd1;
  localparam logic [1:0] CMD_FIFO    = 2'd2;
  localparam logic [1:0] CMD_INVALID = 2'd3;

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [4:0]  bit_r, bit_s;
  logic        gap_r, gap_s;
  logic [1:0]  cmd_r, cmd_s;
  logic [23:0] tx_r, tx_s;
  logic [15:0] rx_r, rx_s;
  logic [15:0] rd_data_s;
  logic        half_end_s;
  logic        busy_s, done_s, err_s, sclk_s, mosi_s, ncs_s;

  function automatic logic [23:0] build_frame(input logic [1:0] op,
                                              input logic [7:0] addr,
                                              input logic [7:0] data);
    logic [23:0] frame;
    case (op)
      CMD_WRITE: frame = {8'h0A, addr, data};
      CMD_READ:  frame = {8'h0B, addr, 8'h00};
      CMD_FIFO:  frame = {8'h0D, 8'h00, 8'h00};
      default:   frame = 24'h00_0000;
    endcase
    return frame;
  endfunction

  assign half_end_s = (cnt_r == 8'd0);

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = half_end_s ? HALF_RELOAD : (cnt_r - 8'd1);
    bit_s     = bit_r;
    gap_s     = gap_r;
    cmd_s     = cmd_r;
    tx_s      = tx_r;
    rx_s      = rx_r;
    rd_data_s = rd_data;
    err_s     = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = HALF_RELOAD;
        bit_s = 5'd0;
        gap_s = 1'b0;
        if (start) begin
          cmd_s = cmd;
          if (cmd == CMD_INVALID) begin
            state_s = DONE;
            err_s   = 1'b1;
          end else begin
            state_s = CS_SETUP;
            tx_s    = build_frame(cmd, address, wr_data);
          end
        end else begin
          state_s = IDLE;
        end
      end
      CS_SETUP: begin
        if (half_end_s) state_s = SHIFT_LOW;
        else            state_s = CS_SETUP;
      end
      SHIFT_LOW: begin
        // MISO is captured on the same edge that raises SCLK
        if (half_end_s) begin
          state_s = SHIFT_HIGH;
          rx_s    = {rx_r[14:0], MISO};
        end else begin
          state_s = SHIFT_LOW;
        end
      end
      SHIFT_HIGH: begin
        if (half_end_s) begin
          tx_s = {tx_r[22:0], 1'b0};
          if (bit_r == 5'd23) begin
            bit_s   = 5'd0;
            state_s = CS_HOLD;
          end else begin
            bit_s   = bit_r + 5'd1;
            state_s = SHIFT_LOW;
          end
        end else begin
          state_s = SHIFT_HIGH;
        end
      end
      CS_HOLD: begin
        gap_s = 1'b0;
        if (half_end_s) state_s = CS_GAP;
        else            state_s = CS_HOLD;
      end
      CS_GAP: begin
        if (half_end_s) begin
          if (gap_r) begin
            gap_s   = 1'b0;
            state_s = DONE;
            // rx_r holds the last two received bytes: [15:8] byte 2, [7:0] byte 3
            if (cmd_r == CMD_READ)      rd_data_s = {8'h00, rx_r[7:0]};
            else if (cmd_r == CMD_FIFO) rd_data_s = {rx_r[7:0], rx_r[15:8]};
            else                        rd_data_s = rd_data;
          end else begin
            gap_s = 1'b1;
          end
        end else begin
          state_s = CS_GAP;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    done_s = (state_s == DONE);
    busy_s = ((state_s != IDLE) && (state_s != DONE)) || err_s;
    ncs_s  = !(state_s inside {CS_SETUP, SHIFT_LOW, SHIFT_HIGH, CS_HOLD});
    sclk_s = (state_s == SHIFT_HIGH);
    mosi_s = (state_s inside {SHIFT_LOW, SHIFT_HIGH}) ? tx_s[23] : 1'b0;
  end

  // State, datapath and registered bus/handshake outputs.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= HALF_RELOAD;
      bit_r   <= 5'd0;
      gap_r   <= 1'b0;
      cmd_r   <= 2'd0;
      tx_r    <= 24'h00_0000;
      rx_r    <= 16'h0000;
      rd_data <= 16'h0000;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      nCS     <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      gap_r   <= gap_s;
      cmd_r   <= cmd_s;
      tx_r    <= tx_s;
      rx_r    <= rx_s;
      rd_data <= rd_data_s;
      busy    <= busy_s;
      done    <= done_s;
      err     <= err_s;
      SCLK    <= sclk_s;
      MOSI    <= mosi_s;
      nCS     <= ncs_s;
    end
  end

endmodule

// File: tb/tb_pmodacl2_spi_master.sv
// Randomized self-checking bench for pmodacl2_spi_master with a behavioural
// ADXL362-style slave and a frame-level reference model.
module tb_pmodacl2_spi_master;
  localparam int CLK_DIV = 4;
  localparam int T_DONE  = 52 * CLK_DIV;

  logic        clk_sys = 1'b0;
  logic        rst, start;
  logic [1:0]  cmd;
  logic [7:0]  address, wr_data;
  logic [15:0] rd_data;
  logic        busy, done, err, SCLK, MOSI, nCS, MISO;

  pmodacl2_spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk_sys(clk_sys), .rst(rst), .start(start), .cmd(cmd), .address(address),
    .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
    .SCLK(SCLK), .MOSI(MOSI), .nCS(nCS), .MISO(MISO)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Slave side: capture MOSI on rising SCLK, shift MISO out after falling SCLK
  int          rise_cnt = 0, fall_cnt = 0, ncs_falls = 0, fall_base = 0, miso_k;
  logic [23:0] mosi_shift = 24'h0;
  logic [23:0] miso_pat = 24'h0;
  always @(posedge SCLK) begin
    rise_cnt   <= rise_cnt + 1;
    mosi_shift <= {mosi_shift[22:0], MOSI};
  end
  always @(negedge SCLK) fall_cnt <= fall_cnt + 1;
  always @(negedge nCS)  ncs_falls <= ncs_falls + 1;
  assign miso_k = fall_cnt - fall_base;
  assign MISO   = (!nCS && miso_k >= 0 && miso_k < 24) ? miso_pat[5'(23 - miso_k)] : 1'b0;

  logic [7:0]  mem [256];
  logic [15:0] rd_model = 16'h0;
  int          wr_strobes = 0, fifo_pulses = 0, last_done_cyc = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_frame(input logic [1:0] c, input logic [7:0] a,
                                            input logic [7:0] d);
    case (c)
      2'd0:    return {8'h0A, a, d};
      2'd1:    return {8'h0B, a, 8'h00};
      default: return {8'h0D, 16'h0000};
    endcase
  endfunction

  task automatic run_txn(input logic [1:0] c, input logic [7:0] a, input logic [7:0] d,
                         input logic [23:0] pat, input bit hold, output int accept_cyc);
    int rb, nf, n, viol;
    bit seen_done;
    logic prev_mosi, prev_sclk;
    @(posedge clk_sys); #1;
    miso_pat = pat; fall_base = fall_cnt; rb = rise_cnt; nf = ncs_falls;
    cmd = c; address = a; wr_data = d; start = 1'b1;
    @(posedge clk_sys); #1;
    accept_cyc = cyc;
    if (!hold) start = 1'b0;
    check_value("ncs_low_after_start", 32'(nCS), 32'd0);
    check_value("busy_after_start", 32'(busy), 32'd1);
    seen_done = 1'b0; viol = 0; n = 0; prev_mosi = MOSI; prev_sclk = SCLK;
    while (!seen_done && n < T_DONE + 40) begin
      @(posedge clk_sys); #1;
      n++;
      if (done) seen_done = 1'b1;
      else if (!busy) viol++;
      if (nCS && MOSI) viol++;
      if (MOSI !== prev_mosi && prev_sclk && SCLK) viol++;
      prev_mosi = MOSI; prev_sclk = SCLK;
    end
    start = 1'b0;
    check_value("done_latency", n, T_DONE);
    check_value("busy_at_done", 32'(busy), 32'd0);
    check_value("err_at_done", 32'(err), 32'd0);
    check_value("ncs_high_at_done", 32'(nCS), 32'd1);
    check_value("sclk_idle_at_done", 32'(SCLK), 32'd0);
    check_value("bus_protocol", viol, 0);
    check_value("sclk_rises", rise_cnt - rb, 24);
    check_value("mosi_frame", 32'(mosi_shift), 32'(ref_frame(c, a, d)));
    check_value("ncs_fall_count", ncs_falls - nf, 1);
    if (c == 2'd1)      rd_model = {8'h00, pat[7:0]};
    else if (c == 2'd2) rd_model = {pat[7:0], pat[15:8]};
    check_value("rd_data", 32'(rd_data), 32'(rd_model));
    if (mosi_shift[23:16] == 8'h0A) begin
      mem[mosi_shift[15:8]] = mosi_shift[7:0];
      wr_strobes++;
    end
    if (mosi_shift[23:16] == 8'h0D) fifo_pulses++;
    last_done_cyc = cyc;
  endtask

  initial begin
    int acc, nf, dn, wb, fb, rb;
    logic [1:0] c;
    logic [7:0] a, d;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hAD;
    rst = 1'b1; start = 1'b0; cmd = 2'd0; address = 8'h00; wr_data = 8'h00;
    repeat (3) @(posedge clk_sys);
    #1;
    check_value("reset_ncs", 32'(nCS), 32'd1);
    check_value("reset_outputs", {SCLK, MOSI, busy, done, err}, 32'd0);
    check_value("reset_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;

    wb = wr_strobes;
    run_txn(2'd0, 8'h2D, 8'h02, 24'($urandom), 1'b0, acc);
    check_value("slave_write_strobe", wr_strobes - wb, 1);
    check_value("slave_reg_2d", 32'(mem[8'h2D]), 32'h02);

    run_txn(2'd1, 8'h00, 8'h00, {16'($urandom), mem[0]}, 1'b0, acc);
    check_value("read_00ad", 32'(rd_data), 32'h00AD);

    fb = fifo_pulses;
    run_txn(2'd2, 8'h00, 8'h00, {8'($urandom), 8'h34, 8'h12}, 1'b0, acc);
    check_value("fifo_1234", 32'(rd_data), 32'h1234);
    check_value("slave_fifo_pulse", fifo_pulses - fb, 1);

    // Invalid command: one-cycle busy/done/err, no bus activity
    @(posedge clk_sys); #1;
    nf = ncs_falls; cmd = 2'd3; start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    check_value("invalid_done_err_busy", {done, err, busy}, 32'h7);
    check_value("invalid_ncs", 32'(nCS), 32'd1);
    @(posedge clk_sys); #1;
    check_value("invalid_clear", {done, err, busy}, 32'h0);
    check_value("invalid_no_ncs_fall", ncs_falls - nf, 0);
    check_value("invalid_rd_data", 32'(rd_data), 32'(rd_model));

    // Start held through a transaction, then back-to-back restart
    run_txn(2'd1, 8'h2D, 8'h00, {16'($urandom), mem[8'h2D]}, 1'b1, acc);
    dn = last_done_cyc;
    run_txn(2'd0, 8'h1F, 8'h52, 24'($urandom), 1'b0, acc);
    check_value("back_to_back_gap", acc - dn, 2);

    for (int i = 0; i < 12; i++) begin
      c = 2'($urandom_range(0, 2));
      a = 8'($urandom);
      d = 8'($urandom);
      run_txn(c, a, d, (c == 2'd1) ? {16'($urandom), mem[a]} : 24'($urandom), 1'b0, acc);
    end

    run_txn(2'd2, 8'h00, 8'h00, {8'($urandom), 8'h34, 8'h12}, 1'b0, acc);

    // Reset in the middle of a read
    @(posedge clk_sys); #1;
    miso_pat = 24'($urandom); fall_base = fall_cnt; rb = rise_cnt;
    cmd = 2'd1; address = 8'h11; start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    for (int i = 0; i < T_DONE && (rise_cnt - rb) < 10; i++) begin
      @(posedge clk_sys); #1;
    end
    check_value("reached_bit10", rise_cnt - rb, 10);
    rst = 1'b1;
    @(posedge clk_sys); #1;
    check_value("abort_ncs", 32'(nCS), 32'd1);
    check_value("abort_outputs", {SCLK, MOSI, busy, done, err}, 32'd0);
    check_value("abort_rd_data", 32'(rd_data), 32'd0);
    start = 1'b1; cmd = 2'd1;
    @(posedge clk_sys); #1;
    check_value("rst_beats_start", {nCS, busy}, 32'h2);
    rst = 1'b0; start = 1'b0;
    nf = 0;
    for (int i = 0; i < 2 * T_DONE; i++) begin
      @(posedge clk_sys); #1;
      if (done || !nCS) nf++;
    end
    check_value("no_done_after_abort", nf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pmodacl2_spi_master.md
PMODACL2_SPI_MASTER -- requirements
Module: pmodacl2_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk_sys cycles per SCLK half-period; legal range 2..255.
REQ-002 SHALL have port clk_sys  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a transaction.
REQ-005 SHALL have port cmd  input  2  operation: 0 = register write, 1 = register read, 2 = FIFO read, 3 = invalid.
REQ-006 SHALL have port address  input  8  register address (ignored for FIFO read).
REQ-007 SHALL have port wr_data  input  8  write data byte (used for write only).
REQ-008 SHALL have port rd_data  output  16  read result.
REQ-009 SHALL have port busy  output  1  transaction in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  high with done when cmd was invalid.
REQ-012 SHALL have ports SCLK, MOSI, nCS  output  1 each: SPI bus to the ADXL362 slave.
REQ-013 SHALL have port MISO  input  1  SPI data from the slave.

Function
REQ-014 SHALL drive SPI mode 0: SCLK idles low, MOSI changes only while SCLK is low, and MISO is sampled on SCLK rising edges.
REQ-015 SHALL accept start only in IDLE, latching cmd, address and wr_data; start while busy SHALL be ignored.
REQ-016 SHALL implement states IDLE, CS_SETUP, SHIFT_LOW, SHIFT_HIGH, CS_HOLD, CS_GAP, DONE; any undefined encoding SHALL return to IDLE.
REQ-017 SHALL drive nCS low and raise busy on the first clk_sys edge after start is accepted.
REQ-018 SHALL remain in CS_SETUP for one half-period, then send 3 bytes (24 bits) MSB first, each bit taking one SHIFT_LOW and one SHIFT_HIGH half-period.
REQ-019 SHALL send byte sequences: write = 0x0A, address, wr_data; read = 0x0B, address, 0x00; FIFO read = 0x0D, 0x00, 0x00.
REQ-020 SHALL set rd_data for a read to {8'h00, byte 3 MISO}.
REQ-021 SHALL set rd_data for a FIFO read to {byte 3 MISO, byte 2 MISO}, low byte first on the wire.
REQ-022 SHALL leave rd_data unchanged on a write or invalid command.
REQ-023 SHALL hold SCLK low for one half-period in CS_HOLD, then raise nCS and stay in CS_GAP for two half-periods.
REQ-024 SHALL pulse done in DONE, exactly 52*CLK_DIV clk_sys cycles after nCS fell, and SHALL drop busy in the same cycle.
REQ-025 SHALL make rd_data valid when done is high and hold it until the next accepted transaction completes.
REQ-026 SHALL, for cmd = 3, produce no SPI activity and assert done and err together on the cycle after start; busy SHALL be high for that one cycle only.
REQ-027 SHALL allow start in the cycle after done and begin a new transaction with no extra gap.
REQ-028 SHALL count half-periods with a counter reloaded to CLK_DIV-1, and the bit counter SHALL wrap 0..23 without overflow to other state.
REQ-029 SHALL drive MOSI low whenever nCS is high.

Reset
REQ-030 SHALL, when rst is high, on the next clk_sys edge: state IDLE, nCS=1, SCLK=0, MOSI=0, busy=0, done=0, err=0, rd_data=16'h0000.
REQ-031 SHALL abort a transaction that rst interrupts with no done pulse; rst SHALL take priority over a simultaneous start.

Verification
REQ-032 SHALL be verified: write, address 0x2D, data 0x02, CLK_DIV=4 -> MOSI bytes 0x0A,0x2D,0x02; slave write strobe; done 208 cycles after nCS falls.
REQ-033 SHALL be verified: read, address 0x00, slave returns 0xAD -> rd_data=16'h00AD at done; 24 SCLK rising edges.
REQ-034 SHALL be verified: FIFO read, slave sends 0x34 then 0x12 -> rd_data=16'h1234; slave read_data_fifo pulse seen.
REQ-035 SHALL be verified: cmd=3 -> nCS never falls; done=1 and err=1 on the next cycle.
REQ-036 SHALL be verified: start held high during a busy transaction -> exactly one transaction, then a second start on the cycle after done runs back-to-back.
REQ-037 SHALL be verified: rst asserted at bit 10 of a read -> nCS=1, SCLK=0, busy=0 next edge, no done, rd_data=0.
